// File: rtl/hs_light_sink.sv
// Consumer stage for the traffic-light FSM's right-hand 4-phase handshake:
// synchronises the request, captures bundled light data into a FIFO and serves it on valid/ready.
module hs_light_sink #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_reqR,
  output logic                       o_ackR,
  input  logic [1:0]                 i_light_a,
  input  logic [1:0]                 i_light_b,
  output logic [3:0]                 o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [7:0]                 o_tok_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [0:0]             state;
  logic [3:0]             mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          rd_ptr_nxt;
  logic [CW-1:0]          count_after_pop;
  logic                   push;
  logic                   pop;

  // Only this chain samples the asynchronous request.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_reqR};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Full is judged on the registered count, so a same-edge pop never frees a slot for a push.
  assign push            = (state == ST_IDLE) && req_s && (o_count != FULL_CNT);
  assign pop             = o_valid && i_ready;
  assign rd_ptr_nxt      = rd_ptr + PW'(pop);
  assign count_after_pop = o_count - CW'(pop);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_IDLE;
      o_ackR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (push) begin
          state  <= ST_ACK;
          o_ackR <= 1'b1;
        end
        ST_ACK: if (!req_s) begin
          state  <= ST_IDLE;
          o_ackR <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_ackR <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_light_a, i_light_b};
  end

  // The head register looks only at entries written on earlier edges, so a new token
  // shows up one edge after its write while pops take effect immediately.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_count   <= '0;
      o_tok_cnt <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PW'(1);
        o_tok_cnt <= o_tok_cnt + 8'd1;
      end
      rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   o_count <= o_count + CW'(1);
        2'b01:   o_count <= o_count - CW'(1);
        default: o_count <= o_count;
      endcase
      o_valid <= (count_after_pop != '0);
      if (count_after_pop != '0) o_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: tb/tb_hs_light_sink.sv
// Directed self-checking bench for hs_light_sink with a small in-order token scoreboard.
module tb_hs_light_sink;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_reqR;
  logic       o_ackR;
  logic [1:0] i_light_a;
  logic [1:0] i_light_b;
  logic [3:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_count;
  logic [7:0] o_tok_cnt;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         max_cnt = 0;
  logic [3:0] exp_q [$];

  hs_light_sink #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_reqR    (i_reqR),
    .o_ackR    (o_ackR),
    .i_light_a (i_light_a),
    .i_light_b (i_light_b),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_count   (o_count),
    .o_tok_cnt (o_tok_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; any pop about to happen on this edge is checked against the scoreboard.
  task automatic step();
    logic [3:0] want;
    if (o_valid && i_ready) begin
      want = 4'h0;
      if (exp_q.size() != 0) want = exp_q.pop_front();
      checkOutput("pop_data", {4'h0, o_data}, {4'h0, want});
    end
    @(posedge i_clk);
    #1;
    if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
  endtask

  task automatic waitAckFall();
    for (int k = 0; k < 20 && o_ackR; k++) step();
    checkOutput("ack_fall", {7'h0, o_ackR}, 8'h0);
  endtask

  task automatic applyStimulus(input logic [3:0] tok);
    i_light_a = tok[3:2];
    i_light_b = tok[1:0];
    exp_q.push_back(tok);
    i_reqR = 1'b1;
    for (int k = 0; k < 20 && !o_ackR; k++) step();
    checkOutput("ack_rise", {7'h0, o_ackR}, 8'h1);
    i_reqR = 1'b0;
    waitAckFall();
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int k = 0; k < 20 && o_count != 3'd0; k++) step();
    checkOutput("drain_count", {5'h0, o_count}, 8'h0);
    checkOutput("drain_valid", {7'h0, o_valid}, 8'h0);
    checkOutput("drain_sb", 8'(exp_q.size()), 8'h0);
  endtask

  task automatic pulseReset();
    i_rstn = 1'b0;
    exp_q.delete();
    step();
    i_rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] tok0;
    int pulses;
    logic prev_ack;
    logic [3:0] d;

    i_rstn = 1'b0; i_reqR = 1'b0; i_ready = 1'b0; i_light_a = 2'b00; i_light_b = 2'b00;
    #1;
    checkOutput("rst_ack",   {7'h0, o_ackR},  8'h0);
    checkOutput("rst_valid", {7'h0, o_valid}, 8'h0);
    checkOutput("rst_data",  {4'h0, o_data},  8'h0);
    checkOutput("rst_count", {5'h0, o_count}, 8'h0);
    checkOutput("rst_tok",   o_tok_cnt,       8'h0);
    step(); step();
    i_rstn = 1'b1;
    step();

    $display("[TB] single token latency");
    i_ready = 1'b1; i_light_a = 2'b10; i_light_b = 2'b01;
    exp_q.push_back(4'b1001);
    i_reqR = 1'b1;
    step(); step();
    checkOutput("lat_ack_early", {7'h0, o_ackR}, 8'h0);
    step();
    checkOutput("lat_ack",       {7'h0, o_ackR},  8'h1);
    checkOutput("lat_count",     {5'h0, o_count}, 8'h1);
    checkOutput("lat_no_fallthr",{7'h0, o_valid}, 8'h0);
    checkOutput("lat_tok",       o_tok_cnt,       8'h1);
    step();
    checkOutput("lat_valid",     {7'h0, o_valid}, 8'h1);
    checkOutput("lat_data",      {4'h0, o_data},  8'h9);
    step();
    checkOutput("lat_popped",    {5'h0, o_count}, 8'h0);
    i_reqR = 1'b0;
    step(); step();
    checkOutput("fall_ack_early",{7'h0, o_ackR}, 8'h1);
    step();
    checkOutput("fall_ack",      {7'h0, o_ackR}, 8'h0);

    $display("[TB] fill to full and backpressure");
    i_ready = 1'b0;
    applyStimulus(4'h1); checkOutput("fill1", {5'h0, o_count}, 8'h1);
    applyStimulus(4'h6); checkOutput("fill2", {5'h0, o_count}, 8'h2);
    applyStimulus(4'hB); checkOutput("fill3", {5'h0, o_count}, 8'h3);
    applyStimulus(4'hC); checkOutput("fill4", {5'h0, o_count}, 8'h4);
    i_light_a = 2'b11; i_light_b = 2'b11;
    exp_q.push_back(4'hF);
    i_reqR = 1'b1;
    for (int k = 0; k < 6; k++) step();
    checkOutput("full_hold_ack", {7'h0, o_ackR},  8'h0);
    checkOutput("full_hold_cnt", {5'h0, o_count}, 8'h4);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    checkOutput("full_pop_cnt",  {5'h0, o_count}, 8'h3);
    checkOutput("full_pop_ack",  {7'h0, o_ackR},  8'h0);
    checkOutput("full_pop_head", {4'h0, o_data},  8'h6);
    step();
    checkOutput("full_late_ack", {7'h0, o_ackR},  8'h1);
    checkOutput("full_late_cnt", {5'h0, o_count}, 8'h4);
    i_reqR = 1'b0;
    waitAckFall();
    drain();

    $display("[TB] simultaneous push and pop");
    i_ready = 1'b0;
    applyStimulus(4'h3);
    applyStimulus(4'h5);
    checkOutput("pp_pre_cnt", {5'h0, o_count}, 8'h2);
    i_light_a = 2'b10; i_light_b = 2'b10;
    exp_q.push_back(4'hA);
    i_reqR = 1'b1;
    step(); step();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    checkOutput("pp_cnt",  {5'h0, o_count}, 8'h2);
    checkOutput("pp_ack",  {7'h0, o_ackR},  8'h1);
    checkOutput("pp_head", {4'h0, o_data},  8'h5);
    i_reqR = 1'b0;
    waitAckFall();
    drain();

    $display("[TB] reset mid-handshake");
    i_ready = 1'b1; i_light_a = 2'b11; i_light_b = 2'b10;
    exp_q.push_back(4'hE);
    i_reqR = 1'b1;
    step(); step(); step();
    checkOutput("mid_ack_pre", {7'h0, o_ackR}, 8'h1);
    i_rstn = 1'b0;
    #1;
    checkOutput("mid_rst_ack",   {7'h0, o_ackR},  8'h0);
    checkOutput("mid_rst_count", {5'h0, o_count}, 8'h0);
    checkOutput("mid_rst_valid", {7'h0, o_valid}, 8'h0);
    exp_q.delete();
    step();
    i_rstn = 1'b1;
    exp_q.push_back(4'hE);
    step(); step();
    checkOutput("mid_reack_early", {7'h0, o_ackR}, 8'h0);
    step();
    checkOutput("mid_reack", {7'h0, o_ackR}, 8'h1);
    checkOutput("mid_tok",   o_tok_cnt,      8'h1);
    i_reqR = 1'b0;
    waitAckFall();
    drain();

    $display("[TB] 256 handshakes wrap");
    pulseReset();
    i_ready = 1'b1;
    max_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      d = 4'(i);
      applyStimulus(d);
    end
    checkOutput("wrap_tok", o_tok_cnt, 8'h0);
    drain();
    checkOutput("wrap_maxcnt", 8'(max_cnt), 8'h1);

    $display("[TB] one-clock request pulse");
    tok0 = o_tok_cnt;
    i_light_a = 2'b00; i_light_b = 2'b01;
    exp_q.push_back(4'h1);
    i_reqR = 1'b1;
    step();
    i_reqR = 1'b0;
    pulses = 0;
    prev_ack = o_ackR;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_ackR && !prev_ack) pulses++;
      prev_ack = o_ackR;
    end
    checkOutput("glitch_pulses", 8'(pulses), 8'h1);
    checkOutput("glitch_tok", o_tok_cnt, tok0 + 8'd1);
    checkOutput("glitch_ack", {7'h0, o_ackR}, 8'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hs_light_sink.md
# hs_light_sink

Clocked consumer stage for the traffic-light FSM's right-hand 4-phase handshake. It synchronises the FSM's request and captures the bundled light outputs into a small FIFO. It returns the acknowledge and presents the captured tokens on a valid/ready interface for downstream synchronous logic. It sits directly downstream of `fsm`, with `i_reqR` wired to `o_reqR` and `o_ackR` wired to `i_ackR`.

## Interface
- DEPTH, 4: FIFO entries; a power of two, ≥2.
- SYNC_STAGES, 2: flip-flops in the request synchroniser, ≥2.
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_reqR  in  1  4-phase request from the FSM; asynchronous to i_clk.
- o_ackR  out  1  4-phase acknowledge to the FSM; registered.
- i_light_a  in  2  bundled data; stable whenever i_reqR=1.
- i_light_b  in  2  bundled data; stable whenever i_reqR=1.
- o_data  out  4  FIFO head, {light_a, light_b}.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  downstream accepts o_data when o_valid=1.
- o_count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- o_tok_cnt  out  8  total tokens accepted; wraps 255→0.

## Operation
- Synchroniser: i_reqR passes through SYNC_STAGES flops; the last stage is req_s. No other logic samples i_reqR.
- Handshake FSM has two states, IDLE and ACK.
  - IDLE → ACK when req_s=1 and o_count<DEPTH. On that edge: write {i_light_a, i_light_b} to the FIFO tail, set o_ackR=1, and increment o_tok_cnt.
  - IDLE with req_s=1 and FIFO full: hold. o_ackR stays 0, which backpressures the FSM. Capture proceeds on the first edge where o_count<DEPTH.
  - ACK → IDLE when req_s=0. On that edge o_ackR goes to 0. No FIFO write occurs in ACK.
- Data is sampled directly, not through the synchroniser. The bundled-data rule guarantees stability from i_reqR rise until o_ackR rise.
- FIFO uses a circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
  - Pop when o_valid && i_ready.
  - o_count updates by +1 on push only, −1 on pop only, and is unchanged on push+pop in the same cycle.
- Full test uses registered o_count==DEPTH. A pop on the same edge does not enable a push; there is no bypass.
- Empty: o_valid=0. o_data holds the last read location and is don't-care for checking.
- i_ready while o_valid=0 has no effect.
- Reset: state=IDLE, o_ackR=0, o_valid=0, o_data=0, o_count=0, o_tok_cnt=0, pointers=0, synchroniser flops=0. Reset takes effect asynchronously on assertion and releases synchronously with the next edge.
- Reset mid-handshake: o_ackR drops immediately and FIFO contents are discarded. If i_reqR is still 1 after release, it is re-synchronised and accepted as a new token.

## Timing
- i_reqR rising before edge E0 makes req_s=1 after edge E0+SYNC_STAGES−1. o_ackR=1 after the next edge, giving a latency of SYNC_STAGES+1 edges when not full.
- i_reqR falling to o_ackR falling also takes SYNC_STAGES+1 edges.
- Minimum full token cycle is 2·(SYNC_STAGES+1) clocks plus the FSM's own delays.
- Pushed data is visible on o_data/o_valid one edge after the write when the FIFO was empty. No fall-through within the write cycle.
- o_count and o_tok_cnt are registered and change on the same edge as the push or pop that causes them.

## Test plan
- Single token, defaults, i_ready=1, light_a=2'b10, light_b=2'b01 → o_ackR rises 3 edges after reqR rises; o_valid=1 with o_data=4'b1001 one edge later; o_ackR falls 3 edges after reqR falls; o_tok_cnt=1.
- Four tokens with i_ready=0 → o_count 1,2,3,4, in order. A fifth reqR sees o_ackR held at 0. Raising i_ready for 1 cycle gives o_count=3, then the fifth ack after one more edge, o_count=4. FIFO order preserved.
- Push and pop in the same cycle at o_count=2 → o_count stays 2; head advances by one entry.
- Reset asserted while o_ackR=1 with reqR held at 1 → o_ackR=0 and o_count=0 immediately. After release, ack re-asserts 3 edges later; o_tok_cnt=1.
- 256 complete handshakes with i_ready=1 → o_tok_cnt wraps to 0; o_count never exceeds 1; no token lost or duplicated.
- Glitch-free check: i_reqR held high for 1 clock then low → if captured, exactly one token and one full ack pulse; no second write.
